// File: rtl/omsp_spm_key_loader_pkg.sv
// ---------------------------------------------------------------------------
// omsp_spm_key_loader_pkg
//
// Shared definitions for the SPM key loader:
//   - KEY_WORDS(sec) macro: the number of 16-bit words in a key of `sec` bits.
//   - state_e: 3-bit FSM state encoding used by the loader top.
//   - key_words(): function wrapper around KEY_WORDS, so that importers do not
//     depend on macro visibility across compilation units.
// ---------------------------------------------------------------------------
`ifndef KEY_WORDS
`define KEY_WORDS(sec) ((sec) / 16)
`endif

package omsp_spm_key_loader_pkg;

    // Width of one word on the SPM key bus.
    localparam int WORD_W = 16;

    // The encoding is fixed because other control logic may decode it.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_KEY = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WRITE    = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // Number of 16-bit words making up a key of `security` bits.
    function automatic int key_words(input int security);
        return `KEY_WORDS(security);
    endfunction

endpackage

// File: rtl/omsp_spm_key_shift.sv
// ---------------------------------------------------------------------------
// omsp_spm_key_shift
//
// Holds the captured module key as an array of 16-bit words. The word that is
// presented on word_o is always the most significant word that has not been
// written out yet. On load the whole key is captured in parallel. On advance
// the register moves one word toward the output, which is equivalent to a
// left shift of the key by 16 bits, with zeros filling from the bottom.
//
// Ports:
//   clk       : clock
//   srst      : synchronous active-high reset (clears the key)
//   clear_i   : wipe the key (has priority over load/advance)
//   load_i    : capture key_i in parallel
//   advance_i : drop the presented word and bring up the next one
//   key_i     : key to load, MSB first
//   word_o    : word currently presented (the key's top 16 bits)
// ---------------------------------------------------------------------------
module omsp_spm_key_shift
    import omsp_spm_key_loader_pkg::*;
#(
    parameter int SECURITY = 64
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic                advance_i,
    input  logic [SECURITY-1:0] key_i,
    output logic [WORD_W-1:0]   word_o
);

    localparam int NWORDS = key_words(SECURITY);

    // Element 0 is the word presented next; element NWORDS-1 the last one.
    logic [NWORDS-1:0][WORD_W-1:0] words_q;
    logic [NWORDS-1:0][WORD_W-1:0] load_words;

    // Split the key so that element gi holds the gi-th word counting from
    // the most significant end (big-endian layout of the SPM key register).
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_split
            assign load_words[gi] = key_i[SECURITY-1-WORD_W*gi -: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst || clear_i) begin
            words_q <= '0;
        end else if (load_i) begin
            words_q <= load_words;
        end else if (advance_i) begin
            // Element i takes element i+1; the top element is zero-filled.
            words_q <= {{WORD_W{1'b0}}, words_q[NWORDS-1:1]};
        end
    end

    assign word_o = words_q[0];

endmodule

// File: rtl/omsp_spm_key_loader.sv
// ---------------------------------------------------------------------------
// omsp_spm_key_loader
//
// Streams a freshly derived module key into the Sancus SPM key registers.
// The target SPM is selected by its public-section start address. The key is
// written as SECURITY/16 words, most significant word first (index 0).
//
// Ports:
//   mclk, puc_rst  : clock and synchronous active-high reset
//   start, sm_addr : load request and target module address (IDLE only)
//   abort          : cancel a load in progress (highest priority)
//   key_valid, key_data, key_ready : handshake with the crypto engine
//   key_selected   : OR of key_selected over the SPM array
//   spm_key_select : latched target address broadcast to the SPMs
//   write_key, key_in, key_idx : SPM key write bus
//   busy           : high whenever the FSM is not IDLE
//   done, error    : one-cycle completion / failure pulses
//
// All outputs are decodes of registered state. The strobes (key_ready,
// write_key, done, error) are also qualified combinationally by abort and
// key_selected, so a cancel or a lost selection takes effect in that same
// cycle.
// ---------------------------------------------------------------------------
module omsp_spm_key_loader
    import omsp_spm_key_loader_pkg::*;
#(
    parameter int SECURITY     = 64,
    parameter int KEY_IDX_SIZE = $clog2(SECURITY / 16)
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic [15:0]             sm_addr,
    input  logic                    abort,
    input  logic                    key_valid,
    input  logic [SECURITY-1:0]     key_data,
    output logic                    key_ready,
    input  logic                    key_selected,
    output logic [15:0]             spm_key_select,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int NWORDS = key_words(SECURITY);
    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(NWORDS - 1);

    // Reject key widths that cannot be split into at least two 16-bit words.
    generate
        if ((SECURITY % WORD_W) != 0 || SECURITY < 32) begin : g_bad_param
            $error("omsp_spm_key_loader: SECURITY must be a multiple of 16 and >= 32");
        end
    endgenerate

    state_e                  state_q;
    logic [KEY_IDX_SIZE-1:0] cnt_q;
    logic [15:0]             sel_q;

    logic                    busy_w;
    logic                    capture_w;
    logic                    sel_lost_w;
    logic                    write_w;
    logic                    finish_w;
    logic                    to_idle_w;
    logic [WORD_W-1:0]       shift_word;

    // -----------------------------------------------------------------------
    // State decodes. abort masks every strobe in the cycle it is seen, so an
    // aborted load never reports done/error and never acknowledges a key.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_w     = (state_q != ST_IDLE);
        capture_w  = (state_q == ST_WAIT_KEY) && key_valid && !abort;
        sel_lost_w = ((state_q == ST_CHECK) || (state_q == ST_WRITE))
                     && !key_selected && !abort;
        write_w    = (state_q == ST_WRITE) && key_selected && !abort;
        finish_w   = (state_q == ST_FINISH) && !abort;
        // Any edge that lands in IDLE also wipes the captured key.
        to_idle_w  = (busy_w && abort) || sel_lost_w || finish_w;
    end

    // -----------------------------------------------------------------------
    // Sequencer: state, word counter and latched target address.
    // The counter is cleared whenever the FSM heads back to IDLE so key_idx
    // idles at zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The address is only ever latched here, so a start
                    // while busy cannot disturb the selected module.
                    if (start) begin
                        sel_q   <= sm_addr;
                        state_q <= ST_WAIT_KEY;
                    end
                end

                ST_WAIT_KEY: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (key_valid) begin
                        cnt_q   <= '0;
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (abort || !key_selected) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    // Words already written stay written on a failure; the
                    // SPM sees an incomplete key and the caller sees error.
                    if (abort || !key_selected) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + KEY_IDX_SIZE'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_q <= ST_FINISH;
                        end
                    end
                end

                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Key word shifter: loaded on the key_ready handshake, advanced on every
    // accepted write, wiped on the way back to IDLE.
    // -----------------------------------------------------------------------
    omsp_spm_key_shift #(
        .SECURITY (SECURITY)
    ) u_shift (
        .clk       (mclk),
        .srst      (puc_rst),
        .clear_i   (to_idle_w),
        .load_i    (capture_w),
        .advance_i (write_w),
        .key_i     (key_data),
        .word_o    (shift_word)
    );

    // -----------------------------------------------------------------------
    // Outputs. key_in is held at zero outside WRITE so key material is not
    // left on the broadcast bus between writes.
    // -----------------------------------------------------------------------
    assign spm_key_select = sel_q;
    assign write_key      = write_w;
    assign key_in         = (state_q == ST_WRITE) ? shift_word : 16'h0000;
    assign key_idx        = cnt_q;
    assign key_ready      = capture_w;
    assign busy           = busy_w;
    assign done           = finish_w;
    assign error          = sel_lost_w;

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// ---------------------------------------------------------------------------
// tb_omsp_spm_key_loader
//
// Scoreboard bench for the SPM key loader (SECURITY = 64, 4 words).
// Stimulus pushes the expected strobe events (key_ready, write, done, error)
// with their absolute cycle numbers; a monitor pops one entry whenever the
// DUT raises a strobe and compares kind, cycle, key_idx and key_in.
// Inputs change on the falling edge; outputs are sampled 3 time units later.
// ---------------------------------------------------------------------------
module tb_omsp_spm_key_loader;

    localparam int K_READY = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERROR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic        mclk;
    logic        puc_rst;
    logic        start;
    logic [15:0] sm_addr;
    logic        abort;
    logic        key_valid;
    logic [63:0] key_data;
    logic        key_ready;
    logic        key_selected;
    logic [15:0] spm_key_select;
    logic        write_key;
    logic [15:0] key_in;
    logic [1:0]  key_idx;
    logic        busy;
    logic        done;
    logic        error;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;
    int   t0;

    omsp_spm_key_loader #(
        .SECURITY (64)
    ) dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .start          (start),
        .sm_addr        (sm_addr),
        .abort          (abort),
        .key_valid      (key_valid),
        .key_data       (key_data),
        .key_ready      (key_ready),
        .key_selected   (key_selected),
        .spm_key_select (spm_key_select),
        .write_key      (write_key),
        .key_in         (key_in),
        .key_idx        (key_idx),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_READY: return "key_ready";
            K_WRITE: return "write";
            K_DONE:  return "done";
            default: return "error";
        endcase
    endfunction

    function automatic void push(input int kind, input int c, input int idx, input logic [15:0] d);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        e.data = d;
        sb.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, expv);
        end
    endtask

    task automatic chk_drained(input string name);
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Wait until the falling edge that starts cycle c.
    task automatic goto(input int c);
        while (cyc < c) @(negedge mclk);
    endtask

    // Scoreboard monitor.
    always @(negedge mclk) begin
        #3;
        if (mon_en) begin
            int   nev;
            int   kind;
            exp_t e;
            nev = int'(key_ready) + int'(write_key) + int'(done) + int'(error);
            if (nev > 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL multi_event: cycle %0d got %0d strobes required at most 1", cyc, nev);
            end else if (nev == 1) begin
                kind = key_ready ? K_READY : write_key ? K_WRITE : done ? K_DONE : K_ERROR;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d got %s required none", cyc, kname(kind));
                end else begin
                    e = sb.pop_front();
                    if (e.kind != kind || e.cyc != cyc ||
                        (kind == K_WRITE && (e.idx != int'(key_idx) || e.data !== key_in))) begin
                        n_fail++;
                        $display("FAIL event: got %s cyc %0d idx %0d data %h required %s cyc %0d idx %0d data %h",
                                 kname(kind), cyc, key_idx, key_in, kname(e.kind), e.cyc, e.idx, e.data);
                    end else begin
                        $display("event %s cycle %0d idx %0d data %h", kname(kind), cyc, key_idx, key_in);
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        puc_rst      = 1'b1;
        start        = 1'b0;
        sm_addr      = 16'h0000;
        abort        = 1'b0;
        key_valid    = 1'b0;
        key_data     = 64'h0;
        key_selected = 1'b0;

        // ---------------- reset state ----------------
        goto(3);
        puc_rst = 1'b0;
        #3;
        chk("rst_spm_key_select", 64'(spm_key_select), 64'h0);
        chk("rst_key_in",         64'(key_in),         64'h0);
        chk("rst_key_idx",        64'(key_idx),        64'h0);
        chk("rst_strobes",        {60'h0, write_key, key_ready, done, error}, 64'h0);
        chk("rst_busy",           64'(busy),           64'h0);
        mon_en = 1'b1;

        // ---------------- happy path ----------------
        t0 = cyc + 2;
        key_data     = 64'h0123_4567_89AB_CDEF;
        key_valid    = 1'b1;
        key_selected = 1'b1;
        goto(t0);
        start = 1'b1; sm_addr = 16'h6000;
        push(K_READY, t0 + 1, 0, 16'h0);
        push(K_WRITE, t0 + 3, 0, 16'h0123);
        push(K_WRITE, t0 + 4, 1, 16'h4567);
        push(K_WRITE, t0 + 5, 2, 16'h89AB);
        push(K_WRITE, t0 + 6, 3, 16'hCDEF);
        push(K_DONE,  t0 + 7, 0, 16'h0);
        goto(t0 + 1);
        start = 1'b0;
        #3;
        chk("happy_busy_rise", 64'(busy), 64'h1);
        chk("happy_select",    64'(spm_key_select), 64'h6000);
        goto(t0 + 8);
        #3;
        chk("happy_busy_fall", 64'(busy), 64'h0);
        chk_drained("happy_drained");

        // ---------------- no module selected ----------------
        t0 = cyc + 2;
        key_selected = 1'b0;
        goto(t0);
        start = 1'b1;
        push(K_READY, t0 + 1, 0, 16'h0);
        push(K_ERROR, t0 + 2, 0, 16'h0);
        goto(t0 + 1);
        start = 1'b0;
        goto(t0 + 3);
        #3;
        chk("nosel_idle", 64'(busy), 64'h0);
        chk_drained("nosel_drained");

        // ---------------- selection lost mid-write ----------------
        t0 = cyc + 2;
        key_data     = 64'hFEDC_BA98_7654_3210;
        key_selected = 1'b1;
        goto(t0);
        start = 1'b1;
        push(K_READY, t0 + 1, 0, 16'h0);
        push(K_WRITE, t0 + 3, 0, 16'hFEDC);
        push(K_WRITE, t0 + 4, 1, 16'hBA98);
        push(K_ERROR, t0 + 5, 0, 16'h0);
        goto(t0 + 1);
        start = 1'b0;
        goto(t0 + 5);
        key_selected = 1'b0;
        #3;
        chk("lost_write_gated", 64'(write_key), 64'h0);
        goto(t0 + 6);
        #3;
        chk("lost_idle", 64'(busy), 64'h0);
        chk("lost_idx_cleared", 64'(key_idx), 64'h0);
        chk_drained("lost_drained");

        // ---------------- late key, then abort during write ----------------
        t0 = cyc + 2;
        key_selected = 1'b1;
        key_valid    = 1'b0;
        key_data     = 64'hAAAA_5555_1234_8001;
        goto(t0);
        start = 1'b1;
        goto(t0 + 1);
        start = 1'b0;
        #3;
        chk("late_waiting", 64'(busy), 64'h1);
        goto(t0 + 6);
        key_valid = 1'b1;
        push(K_READY, t0 + 6, 0, 16'h0);
        push(K_WRITE, t0 + 8, 0, 16'hAAAA);
        goto(t0 + 9);
        abort = 1'b1;
        #3;
        chk("abort_write_gated", 64'(write_key), 64'h0);
        goto(t0 + 10);
        abort = 1'b0;
        #3;
        chk("abort_idle",     64'(busy), 64'h0);
        chk("abort_key_zero", dut.u_shift.words_q, 64'h0);
        chk("abort_key_in",   64'(key_in), 64'h0);
        chk_drained("abort_drained");

        // ---------------- abort coinciding with key_valid ----------------
        t0 = cyc + 2;
        key_valid = 1'b0;
        goto(t0);
        start = 1'b1;
        goto(t0 + 1);
        start = 1'b0;
        goto(t0 + 2);
        abort = 1'b1; key_valid = 1'b1;
        #3;
        chk("abort_no_ready", 64'(key_ready), 64'h0);
        goto(t0 + 3);
        abort = 1'b0;
        #3;
        chk("abort_wait_idle", 64'(busy), 64'h0);
        chk_drained("abortwait_drained");

        // ---------------- start while busy ----------------
        t0 = cyc + 2;
        key_data = 64'h1111_2222_3333_4444;
        goto(t0);
        start = 1'b1; sm_addr = 16'h6000;
        push(K_READY, t0 + 1, 0, 16'h0);
        push(K_WRITE, t0 + 3, 0, 16'h1111);
        push(K_WRITE, t0 + 4, 1, 16'h2222);
        push(K_WRITE, t0 + 5, 2, 16'h3333);
        push(K_WRITE, t0 + 6, 3, 16'h4444);
        push(K_DONE,  t0 + 7, 0, 16'h0);
        goto(t0 + 1);
        start = 1'b0;
        goto(t0 + 4);
        start = 1'b1; sm_addr = 16'h7000;
        goto(t0 + 5);
        start = 1'b0;
        #3;
        chk("busy_start_select", 64'(spm_key_select), 64'h6000);
        goto(t0 + 8);
        #3;
        chk("busy_start_idle",   64'(busy), 64'h0);
        chk("busy_start_select_end", 64'(spm_key_select), 64'h6000);
        chk_drained("busystart_drained");

        // ---------------- reset mid-operation ----------------
        t0 = cyc + 2;
        key_data = 64'hDEAD_BEEF_CAFE_F00D;
        goto(t0);
        start = 1'b1; sm_addr = 16'h6000;
        push(K_READY, t0 + 1, 0, 16'h0);
        push(K_WRITE, t0 + 3, 0, 16'hDEAD);
        push(K_WRITE, t0 + 4, 1, 16'hBEEF);
        goto(t0 + 1);
        start = 1'b0;
        goto(t0 + 4);
        puc_rst = 1'b1;
        goto(t0 + 5);
        #3;
        chk("midrst_select",  64'(spm_key_select), 64'h0);
        chk("midrst_key_in",  64'(key_in), 64'h0);
        chk("midrst_key_idx", 64'(key_idx), 64'h0);
        chk("midrst_strobes", {60'h0, write_key, key_ready, done, error}, 64'h0);
        chk("midrst_busy",    64'(busy), 64'h0);
        chk("midrst_key_zero", dut.u_shift.words_q, 64'h0);
        goto(t0 + 6);
        puc_rst = 1'b0;
        goto(t0 + 8);
        #3;
        chk_drained("midrst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/omsp_spm_key_loader.md
# omsp_spm_key_loader

Sequencer that sits directly upstream of the Sancus protected-module (SPM) key registers. It takes a freshly derived module key from the crypto engine, selects the target module by its public-section start address, and streams the key into the SPM array as 16-bit words over the `spm_key_select` / `write_key` / `key_in` / `key_idx` bus. It also reports completion or failure to the instruction/control logic that issued the load.

## Interface
Parameters:
- `SECURITY`, default 64: key width in bits; must be a multiple of 16 and ≥ 32.
- `KEY_IDX_SIZE`, default `$clog2(SECURITY/16)`: width of the word index.

Ports (one clock; reset is synchronous and active-high):
- `mclk` in 1: system clock; all state changes on its rising edge.
- `puc_rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to load a key. Ignored unless the block is IDLE.
- `sm_addr` in 16: public-section start address of the target module; sampled on `start`.
- `abort` in 1: cancel any load in progress.
- `key_valid` in 1: crypto engine has a key on `key_data`.
- `key_data` in SECURITY: derived key; MSB first.
- `key_ready` out 1: one-cycle acknowledge that `key_data` was captured.
- `key_selected` in 1: OR over all SPMs of their `key_selected`.
- `spm_key_select` out 16: address broadcast to the SPM array.
- `write_key` out 1: write strobe to the SPM key register.
- `key_in` out 16: key word being written.
- `key_idx` out KEY_IDX_SIZE: index of the word being written.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the load completed successfully.
- `error` out 1: one-cycle pulse when no module was selected or the selection was lost.

## Operation
- NWORDS = SECURITY/16.
- The FSM has five states: IDLE, WAIT_KEY, CHECK, WRITE, FINISH.
- IDLE:
  - On `start`, latch `sm_addr` into `spm_key_select` and go to WAIT_KEY.
  - `spm_key_select` keeps its last value while in IDLE.
- WAIT_KEY:
  - On `key_valid`, capture `key_data` into an internal shift register, pulse `key_ready` in the same cycle, clear the word counter, and go to CHECK.
  - The block waits indefinitely for `key_valid`.
- CHECK:
  - If `key_selected` is high, go to WRITE.
  - Otherwise pulse `error` and go to IDLE; no write occurs.
- WRITE:
  - `write_key` is high every cycle in this state.
  - `key_idx` equals the counter.
  - `key_in` for counter i is `key_data[SECURITY-1-16*i -: 16]`, so index 0 carries the most significant word. This matches the SPM's big-endian `[0:SECURITY-1]` key layout.
  - The counter increments each cycle. After the write with i = NWORDS-1, go to FINISH.
- Loss of selection during WRITE:
  - If `key_selected` is low in any WRITE cycle, `write_key` is forced low in that cycle, `error` pulses, and the FSM goes to IDLE.
  - Words already written are not rolled back.
- FINISH: pulse `done` and go to IDLE.
- `abort` has priority over every transition:
  - From any non-IDLE state, the next state is IDLE.
  - In the abort cycle, `write_key` is gated low combinationally.
  - `done` and `error` are not pulsed.
  - `key_ready` is not asserted if `abort` and `key_valid` coincide.
- `start` while busy is ignored; the latched address does not change.
- The captured key register is zeroed on entry to IDLE so key material does not persist.

## Timing
- Reset values:
  - State = IDLE.
  - `spm_key_select`, `key_in`, `key_idx` = 0.
  - `write_key`, `key_ready`, `busy`, `done`, `error` = 0.
  - Key register and counter = 0.
- `puc_rst` during any state returns the FSM to IDLE at the next edge, with no `done` or `error`.
- Happy-path latency, with `start` in cycle 0 and `key_valid` already high:
  - Cycle 1: WAIT_KEY, `key_ready` = 1.
  - Cycle 2: CHECK.
  - Cycles 3 .. 2+NWORDS: WRITE.
  - Cycle 3+NWORDS: `done` = 1.
  - Cycle 4+NWORDS: IDLE, `busy` = 0.
- `busy` rises in cycle 1.
- A new `start` is accepted in the first cycle after `busy` falls.
- `write_key`, `key_in`, `key_idx` are registered-state decodes that are valid for the whole cycle. The SPM samples them on the following edge.
- `key_selected` is combinational from `spm_key_select`; it is stable from cycle 1 onward.

## Structure
- Shared package/defines file holds:
  - FSM state encoding (3-bit): IDLE = 0, WAIT_KEY = 1, CHECK = 2, WRITE = 3, FINISH = 4.
  - A `KEY_WORDS` macro derived from `SECURITY`.
- The key shifter is a natural sub-module, `omsp_spm_key_shift`. It loads SECURITY bits in parallel and on each advance presents the top 16 bits, then shifts left by 16.
- The FSM, counter and output gating stay in the top module.

## Test plan
All scenarios use `SECURITY` = 64, NWORDS = 4.
- **Happy path.** Reset; `start` with `sm_addr` = 16'h6000; `key_valid` held with key 64'h0123_4567_89AB_CDEF; `key_selected` = 1. Required response:
  - `key_ready` in cycle 1.
  - Writes in cycles 3..6 with `key_idx`/`key_in` = 0/0123, 1/4567, 2/89AB, 3/CDEF.
  - `done` in cycle 7; `busy` low in cycle 8.
- **No module selected.** Same stimulus with `key_selected` = 0. Required: `error` in cycle 2, no `write_key` ever, `done` never, IDLE in cycle 3.
- **Selection lost mid-write.** `key_selected` drops in the WRITE cycle with i = 2. Required: only idx 0 and 1 written, `write_key` low in that cycle, `error` pulses, IDLE next.
- **Abort and late key.**
  - `key_valid` delayed 5 cycles: required `key_ready` exactly on its first high cycle.
  - `abort` in the WRITE cycle with i = 1: required only idx 0 written, no `done`/`error`, IDLE next, key register = 0.
- **Start while busy; reset mid-operation.**
  - `start` with `sm_addr` = 16'h7000 during WRITE: required no effect, `spm_key_select` stays 16'h6000.
  - `puc_rst` in cycle 4: required all outputs at reset values at the next edge.
